// File: rtl/ids_in_arb.sv
// Packet-granular round-robin arbiter feeding one IDS pipeline from two fallthrough FIFOs.
// Optional per-input packet counters are enabled by defining IDS_ARB_STATS_EN.
module ids_in_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic [CTRL_WIDTH-1:0] in0_ctrl,
    input  logic                  in0_empty,
    output logic                  in0_rd_en,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic [CTRL_WIDTH-1:0] in1_ctrl,
    input  logic                  in1_empty,
    output logic                  in1_rd_en,
    input  logic [1:0]            arb_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [1:0]            grant,
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  prio_q, prio_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic                  wr_q;

    logic                  req0, req1;
    logic                  pop;
    logic [DATA_WIDTH-1:0] popData;
    logic [CTRL_WIDTH-1:0] popCtrl;
    logic                  popIsCtrl;
    logic                  eopPop;

    // Pops are only issued by the owner of a registered grant, so the selected head is stable.
    always_comb begin
        in0_rd_en = grant_q[0] && !in0_empty && out_rdy && (state_q != IDLE);
        in1_rd_en = grant_q[1] && !in1_empty && out_rdy && (state_q != IDLE);
        pop       = in0_rd_en || in1_rd_en;
        popData   = grant_q[1] ? in1_data : in0_data;
        popCtrl   = grant_q[1] ? in1_ctrl : in0_ctrl;
        popIsCtrl = |popCtrl;
        eopPop    = pop && popIsCtrl && (state_q == BODY);
        req0      = !in0_empty && arb_en[0];
        req1      = !in1_empty && arb_en[1];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    grant_d = prio_q ? 2'b10 : 2'b01;
                    state_d = HDR;
                end else if (req0) begin
                    grant_d = 2'b01;
                    state_d = HDR;
                end else if (req1) begin
                    grant_d = 2'b10;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (pop && !popIsCtrl) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                // EOP releases the grant and hands priority to the other input.
                if (eopPop) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    prio_d  = grant_q[0];
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            ctrl_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            wr_q <= pop;
            if (pop) begin
                data_q <= popData;
                ctrl_q <= popCtrl;
            end
        end
    end

    assign out_data = data_q;
    assign out_ctrl = ctrl_q;
    assign out_wr   = wr_q;
    assign grant    = grant_q;

`ifdef IDS_ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

    // Clear outranks a coincident EOP increment; counters wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (stats_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (eopPop && grant_q[0]) begin
                cnt0_q <= cnt0_q + CNT_ONE;
            end
            if (eopPop && grant_q[1]) begin
                cnt1_q <= cnt1_q + CNT_ONE;
            end
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`else
    logic unusedStatsClr;

    assign unusedStatsClr = stats_clr;
    assign pkt_cnt0       = '0;
    assign pkt_cnt1       = '0;
`endif

endmodule

// File: tb/tb_ids_in_arb.sv
// Scoreboard bench for ids_in_arb: FIFO models feed directed packets, a monitor checks the stream.
// Counter expectations follow IDS_ARB_STATS_EN the same way the design does.
module tb_ids_in_arb;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NW = 3;
`ifdef IDS_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in0_data, in1_data;
    logic [CW-1:0] in0_ctrl, in1_ctrl;
    logic          in0_empty, in1_empty;
    logic          in0_rd_en, in1_rd_en;
    logic [1:0]    arb_en;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy;
    logic [1:0]    grant;
    logic          stats_clr;
    logic [NW-1:0] pkt_cnt0, pkt_cnt1;

    logic [DW+CW-1:0] q0[$];
    logic [DW+CW-1:0] q1[$];
    logic [DW+CW-1:0] sb[$];

    int   errCount   = 0;
    int   checkCount = 0;
    logic pop0, pop1;
    bit   rdyToggle  = 1'b0;
    bit   prevPop    = 1'b0;
    bit   prevRst    = 1'b0;

    always #5 clk = ~clk;

    ids_in_arb #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .CNT_WIDTH (NW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in0_data (in0_data),
        .in0_ctrl (in0_ctrl),
        .in0_empty(in0_empty),
        .in0_rd_en(in0_rd_en),
        .in1_data (in1_data),
        .in1_ctrl (in1_ctrl),
        .in1_empty(in1_empty),
        .in1_rd_en(in1_rd_en),
        .arb_en   (arb_en),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .grant    (grant),
        .stats_clr(stats_clr),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Word k of a packet: k=0 header, 1..nBody body, nBody+1 EOP; payload tags source/id/index.
    function automatic logic [71:0] mkWord(input int src, input int id, input int k, input int nBody);
        logic [7:0]  c;
        logic [63:0] d;
        c = (k == 0) ? 8'hff : ((k == nBody + 1) ? 8'h01 : 8'h00);
        d = {8'(32'hA0 + src), 8'(id), 8'(k), 40'h0123456789};
        return {c, d};
    endfunction

    task automatic applyStimulus(input int src, input int id, input int nBody, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            if (src == 0) q0.push_back(mkWord(src, id, k, nBody));
            else          q1.push_back(mkWord(src, id, k, nBody));
        end
    endtask

    task automatic expectPkt(input int src, input int id, input int nBody);
        for (int k = 0; k <= nBody + 1; k++) sb.push_back(mkWord(src, id, k, nBody));
    endtask

    task automatic driveFifos();
        in0_empty = (q0.size() == 0);
        in1_empty = (q1.size() == 0);
        if (q0.size() != 0) {in0_ctrl, in0_data} = q0[0];
        else                {in0_ctrl, in0_data} = '0;
        if (q1.size() != 0) {in1_ctrl, in1_data} = q1[0];
        else                {in1_ctrl, in1_data} = '0;
    endtask

    // Sample pop requests at the negedge, retire them after the posedge, then re-drive.
    task automatic stepCycle();
        @(negedge clk);
        pop0 = in0_rd_en;
        pop1 = in1_rd_en;
        @(posedge clk);
        #1;
        if (pop0 && q0.size() != 0) void'(q0.pop_front());
        if (pop1 && q1.size() != 0) void'(q1.pop_front());
        if (rdyToggle) out_rdy = ~out_rdy;
        driveFifos();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && grant == 2'b00 && !out_wr)
               && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput({name, "_drained"}, 72'(n < budget), 72'(1));
    endtask

    task automatic applyReset();
        reset_n   = 1'b0;
        q0.delete();
        q1.delete();
        sb.delete();
        rdyToggle = 1'b0;
        out_rdy   = 1'b1;
        arb_en    = 2'b11;
        stats_clr = 1'b0;
        driveFifos();
        stepCycle();
        stepCycle();
        reset_n = 1'b1;
    endtask

    // Monitor: every written word must be the next scoreboard entry; pops must obey the rules.
    always @(negedge clk) begin
        if (reset_n && prevRst) checkOutput("wr_follows_pop", 72'(out_wr), 72'(prevPop));
        if (out_wr) begin
            if (sb.size() == 0) begin
                checkCount++;
                errCount++;
                $display("[TB] FAIL unexpected_word: got %0h, want none", {out_ctrl, out_data});
            end else begin
                checkOutput("word", 72'({out_ctrl, out_data}), sb.pop_front());
            end
        end
        checkOutput("rd_en_exclusive", 72'(in0_rd_en & in1_rd_en), 72'(0));
        if (in0_rd_en || in1_rd_en) checkOutput("rd_en_needs_rdy", 72'(out_rdy), 72'(1));
        if (in0_rd_en) checkOutput("rd0_granted", 72'(grant), 72'(2'b01));
        if (in1_rd_en) checkOutput("rd1_granted", 72'(grant), 72'(2'b10));
        prevPop = in0_rd_en || in1_rd_en;
        prevRst = reset_n;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [71:0] w;

        applyReset();
        checkOutput("rst_out_wr", 72'(out_wr), 72'(0));
        checkOutput("rst_out_data", 72'(out_data), 72'(0));
        checkOutput("rst_out_ctrl", 72'(out_ctrl), 72'(0));
        checkOutput("rst_grant", 72'(grant), 72'(0));
        checkOutput("rst_cnt0", 72'(pkt_cnt0), 72'(0));
        checkOutput("rst_cnt1", 72'(pkt_cnt1), 72'(0));

        $display("[TB] test 1: single packet on in0");
        applyStimulus(0, 1, 3, 0, 4);
        expectPkt(0, 1, 3);
        driveFifos();
        stepCycle();
        checkOutput("t1_grant", 72'(grant), 72'(2'b01));
        checkOutput("t1_gap", 72'(out_wr), 72'(0));
        stepCycle();
        w = mkWord(0, 1, 0, 3);
        checkOutput("t1_first_wr", 72'(out_wr), 72'(1));
        checkOutput("t1_first_word", 72'({out_ctrl, out_data}), w);
        drain("t1", 50);
        checkOutput("t1_grant_idle", 72'(grant), 72'(2'b00));

        $display("[TB] test 2: three packets on each input alternate");
        applyReset();
        for (int p = 0; p < 3; p++) begin
            applyStimulus(0, 10 + p, 1, 0, 2);
            applyStimulus(1, 20 + p, 2, 0, 3);
            expectPkt(0, 10 + p, 1);
            expectPkt(1, 20 + p, 2);
        end
        driveFifos();
        drain("t2", 200);
        checkOutput("t2_cnt0", 72'(pkt_cnt0), 72'(STATS ? 3 : 0));
        checkOutput("t2_cnt1", 72'(pkt_cnt1), 72'(STATS ? 3 : 0));

        $display("[TB] test 3: out_rdy toggling");
        applyReset();
        rdyToggle = 1'b1;
        applyStimulus(0, 30, 3, 0, 4);
        expectPkt(0, 30, 3);
        driveFifos();
        drain("t3", 100);
        rdyToggle = 1'b0;
        out_rdy   = 1'b1;

        $display("[TB] test 4: granted FIFO runs dry mid-packet");
        applyReset();
        applyStimulus(0, 40, 3, 0, 1);
        applyStimulus(1, 41, 1, 0, 2);
        expectPkt(0, 40, 3);
        expectPkt(1, 41, 1);
        driveFifos();
        repeat (3) stepCycle();
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("t4_grant_held", 72'(grant), 72'(2'b01));
            checkOutput("t4_no_in1_pop", 72'(in1_rd_en), 72'(0));
        end
        applyStimulus(0, 40, 3, 2, 4);
        driveFifos();
        drain("t4", 100);

        $display("[TB] test 5: arb_en gating");
        applyReset();
        arb_en = 2'b10;
        applyStimulus(0, 50, 2, 0, 3);
        applyStimulus(1, 51, 3, 0, 4);
        expectPkt(1, 51, 3);
        expectPkt(0, 50, 2);
        driveFifos();
        stepCycle();
        checkOutput("t5_only_in1", 72'(grant), 72'(2'b10));
        stepCycle();
        stepCycle();
        arb_en = 2'b01;
        drain("t5", 100);

        $display("[TB] test 6: asynchronous reset mid-packet");
        applyReset();
        applyStimulus(0, 60, 3, 0, 4);
        expectPkt(0, 60, 3);
        driveFifos();
        repeat (4) stepCycle();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_out_wr", 72'(out_wr), 72'(0));
        checkOutput("t6_out_data", 72'(out_data), 72'(0));
        checkOutput("t6_out_ctrl", 72'(out_ctrl), 72'(0));
        checkOutput("t6_grant", 72'(grant), 72'(0));
        checkOutput("t6_rd_en", 72'(in0_rd_en), 72'(0));
        applyReset();

        $display("[TB] test 6b: counter wrap and clear priority");
        for (int p = 0; p < 7; p++) begin
            applyStimulus(0, 70 + p, 1, 0, 2);
            expectPkt(0, 70 + p, 1);
        end
        driveFifos();
        drain("t6_seven", 300);
        checkOutput("t6_cnt_max", 72'(pkt_cnt0), 72'(STATS ? 7 : 0));
        applyStimulus(0, 80, 1, 0, 2);
        expectPkt(0, 80, 1);
        driveFifos();
        drain("t6_wrap", 50);
        checkOutput("t6_cnt_wrap", 72'(pkt_cnt0), 72'(0));
        applyStimulus(0, 81, 1, 0, 2);
        expectPkt(0, 81, 1);
        driveFifos();
        drain("t6_after_wrap", 50);
        checkOutput("t6_cnt_one", 72'(pkt_cnt0), 72'(STATS ? 1 : 0));
        stats_clr = 1'b1;
        applyStimulus(0, 82, 1, 0, 2);
        expectPkt(0, 82, 1);
        driveFifos();
        drain("t6_clr", 50);
        stats_clr = 1'b0;
        checkOutput("t6_cnt_clr_wins", 72'(pkt_cnt0), 72'(0));
        checkOutput("t6_cnt1_idle", 72'(pkt_cnt1), 72'(0));

        stepCycle();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
